// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if
//   Output bundle of the WS2812 line receiver.
//
//   Handshake: there is no ready signal. Every *_vld / *_done / err strobe is
//   a single-cycle pulse that the consumer must take in that same cycle.
//   pixel_data_out and pixel_idx_out are valid while pixel_vld_out is 1 and
//   hold their last value otherwise.
//
//   Signals
//     pixel_vld_out   1      pulse: pixel_data_out / pixel_idx_out valid
//     pixel_data_out  24     received pixel, first bit on the line in [23]
//     pixel_idx_out   IDX_W  index of the pixel within the current frame
//     frame_done_out  1      pulse: reset code seen after >=1 bit in the frame
//     err_out         1      pulse: protocol error
//     state_dbg_out   2      receiver state (0 SYNC, 1 IDLE, 2 HIGH, 3 LOW)
//
//   Modports: master = receiver (drives everything), slave = consumer.
interface ws2812_rx_if #(
    parameter int IDX_W = 8
);
    logic             pixel_vld_out;
    logic [23:0]      pixel_data_out;
    logic [IDX_W-1:0] pixel_idx_out;
    logic             frame_done_out;
    logic             err_out;
    logic [1:0]       state_dbg_out;

    modport master (
        output pixel_vld_out,
        output pixel_data_out,
        output pixel_idx_out,
        output frame_done_out,
        output err_out,
        output state_dbg_out
    );

    modport slave (
        input pixel_vld_out,
        input pixel_data_out,
        input pixel_idx_out,
        input frame_done_out,
        input err_out,
        input state_dbg_out
    );
endinterface

// File: rtl/ws2812_rx.sv
// ws2812_rx
//   WS2812 single-wire receiver. Synchronises the data line, measures every
//   high pulse, decodes it as a 0 or 1 bit, assembles 24-bit pixels MSB-first
//   and tags each with its index in the frame. A long low (reset code) ends
//   the frame. Malformed pulses raise err_out and force a resync.
//
//   Ports
//     clk_in     in  1   clock
//     rst_n_in   in  1   asynchronous active-low reset
//     din_in     in  1   WS2812 data line, asynchronous to clk_in
//     rx_if      master  pixel / frame / error outputs (see ws2812_rx_if)
//
//   Latency: an output pulse appears 3 clk_in cycles after the din_in edge
//   that caused it (2 synchroniser stages + registered outputs).
module ws2812_rx #(
    parameter logic [15:0] CNT_MIN_H = 16'd5,
    parameter logic [15:0] CNT_THR_H = 16'd30,
    parameter logic [15:0] CNT_MAX_H = 16'd100,
    parameter logic [15:0] CNT_RST   = 16'd2500,
    parameter int          IDX_W     = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        din_in,
    ws2812_rx_if.master rx_if
);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_IDLE = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    state_t           state_q, state_d;

    logic             sync1_q, sync2_q, prev_q;
    logic [15:0]      h_cnt_q, l_cnt_q;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [22:0]      shift_q, shift_d;
    logic [IDX_W-1:0] pix_idx_q, pix_idx_d;

    logic             pixel_vld_q, pixel_vld_d;
    logic [23:0]      pixel_data_q, pixel_data_d;
    logic [IDX_W-1:0] pixel_idx_q, pixel_idx_d;
    logic             frame_done_q, frame_done_d;
    logic             err_q, err_d;

    logic             rise, fall;
    logic             bit_val;
    logic [23:0]      new_word;

    // Edges come from the synchronised copy only, never from din_in itself.
    assign rise     = sync2_q & ~prev_q;
    assign fall     = ~sync2_q & prev_q;
    assign bit_val  = (h_cnt_q >= CNT_THR_H);
    assign new_word = {shift_q, bit_val};

    // Synchroniser, edge-detect copy and saturating width counters.
    // h_cnt_q equals the high width in cycles on the cycle where fall is seen.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            h_cnt_q <= 16'd0;
            l_cnt_q <= 16'd0;
        end else begin
            sync1_q <= din_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (sync2_q) begin
                h_cnt_q <= (h_cnt_q == 16'hFFFF) ? h_cnt_q : h_cnt_q + 16'd1;
                l_cnt_q <= 16'd0;
            end else begin
                h_cnt_q <= 16'd0;
                l_cnt_q <= (l_cnt_q == 16'hFFFF) ? l_cnt_q : l_cnt_q + 16'd1;
            end
        end
    end

    // State, pixel assembly and registered outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= ST_SYNC;
            bit_cnt_q    <= 5'd0;
            shift_q      <= 23'd0;
            pix_idx_q    <= '0;
            pixel_vld_q  <= 1'b0;
            pixel_data_q <= 24'd0;
            pixel_idx_q  <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pix_idx_q    <= pix_idx_d;
            pixel_vld_q  <= pixel_vld_d;
            pixel_data_q <= pixel_data_d;
            pixel_idx_q  <= pixel_idx_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pix_idx_d    = pix_idx_q;
        pixel_vld_d  = 1'b0;
        pixel_data_d = pixel_data_q;
        pixel_idx_d  = pixel_idx_q;
        frame_done_d = 1'b0;
        err_d        = 1'b0;

        case (state_q)
            ST_SYNC: begin
                // Hold the frame state cleared until the line has been quiet
                // for a full reset code; pulses seen here are ignored.
                bit_cnt_d = 5'd0;
                shift_d   = 23'd0;
                pix_idx_d = '0;
                if (!sync2_q && l_cnt_q == CNT_RST) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end
            end

            ST_HIGH: begin
                if (fall) begin
                    if (h_cnt_q < CNT_MIN_H || h_cnt_q > CNT_MAX_H) begin
                        err_d     = 1'b1;
                        state_d   = ST_SYNC;
                        bit_cnt_d = 5'd0;
                        shift_d   = 23'd0;
                        pix_idx_d = '0;
                    end else begin
                        state_d = ST_LOW;
                        if (bit_cnt_q == 5'd23) begin
                            pixel_vld_d  = 1'b1;
                            pixel_data_d = new_word;
                            pixel_idx_d  = pix_idx_q;
                            pix_idx_d    = pix_idx_q + IDX_W'(1);
                            bit_cnt_d    = 5'd0;
                            shift_d      = 23'd0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                            shift_d   = new_word[22:0];
                        end
                    end
                end else if (h_cnt_q > CNT_MAX_H) begin
                    // Stuck-high line: flag once and leave without waiting
                    // for the fall; SYNC does not look at h_cnt.
                    err_d     = 1'b1;
                    state_d   = ST_SYNC;
                    bit_cnt_d = 5'd0;
                    shift_d   = 23'd0;
                    pix_idx_d = '0;
                end
            end

            ST_LOW: begin
                if (rise) begin
                    state_d = ST_HIGH;
                end else if (l_cnt_q == CNT_RST) begin
                    // End of frame; a partial pixel is dropped and flagged.
                    frame_done_d = 1'b1;
                    err_d        = (bit_cnt_q != 5'd0);
                    bit_cnt_d    = 5'd0;
                    shift_d      = 23'd0;
                    pix_idx_d    = '0;
                    state_d      = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_SYNC;
            end
        endcase
    end

    assign rx_if.pixel_vld_out  = pixel_vld_q;
    assign rx_if.pixel_data_out = pixel_data_q;
    assign rx_if.pixel_idx_out  = pixel_idx_q;
    assign rx_if.frame_done_out = frame_done_q;
    assign rx_if.err_out        = err_q;
    assign rx_if.state_dbg_out  = state_q;

endmodule
